// File: rtl/execute_alu_wb_pkg.sv
// Shared definitions for the ALU writeback buffer: entry field widths,
// the writeback payload layout and the head-of-queue state encodings.
package execute_alu_wb_pkg;

  localparam int unsigned ROB_W  = 4;
  localparam int unsigned FID_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DLY_W  = 4;

  // Payload held per buffer entry (delay counter lives in its own sub-module)
  typedef struct packed {
    logic [ROB_W-1:0]  rob;
    logic [FID_W-1:0]  fid;
    logic [DATA_W-1:0] result;
  } wb_payload_t;

  // Head-of-queue view: nothing held, head still counting down, head presentable
  typedef enum logic [1:0] {
    HS_EMPTY   = 2'd0,
    HS_WAIT    = 2'd1,
    HS_PRESENT = 2'd2
  } head_state_t;

endpackage

// File: rtl/execute_alu_wb_delay_cnt.sv
// Per-entry saturating commit-delay counter.
// Ports: clk/resetn (async active-low), i_load + i_load_val load a new delay,
//        i_clear zeroes the counter, o_cnt is the current (registered) count.
// Otherwise the count decrements by one per rising edge and holds at zero.
module execute_alu_wb_delay_cnt
  import execute_alu_wb_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [DLY_W-1:0] i_load_val,
  input  logic             i_clear,
  output logic [DLY_W-1:0] o_cnt
);

  logic [DLY_W-1:0] r_cnt;

  // Clear wins over load so a flush discards the entry being written
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - DLY_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/execute_alu_wb.sv
// In-order ALU writeback buffer. Each result is held for i_cmtdelay cycles
// and then presented to the ROB writeback port until accepted.
// Ports: clk, resetn (async active-low); input side i_valid/i_dst_rob/i_fid/
//        i_result/i_cmtdelay with o_ready; i_flush discards everything;
//        writeback side o_wb_valid/o_wb_dst_rob/o_wb_fid/o_wb_result with
//        i_wb_ready. Data outputs read zero while o_wb_valid is low.
// Config: define EXECUTE_ALU_WB_BYPASS_EN to present a zero-delay input in
//         the same cycle when the buffer is empty.
module execute_alu_wb
  import execute_alu_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_valid,
  input  logic [ROB_W-1:0]  i_dst_rob,
  input  logic [FID_W-1:0]  i_fid,
  input  logic [DATA_W-1:0] i_result,
  input  logic [DLY_W-1:0]  i_cmtdelay,
  output logic              o_ready,
  input  logic              i_flush,
  output logic              o_wb_valid,
  output logic [ROB_W-1:0]  o_wb_dst_rob,
  output logic [FID_W-1:0]  o_wb_fid,
  output logic [DATA_W-1:0] o_wb_result,
  input  logic              i_wb_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_payload_t      r_mem [DEPTH];
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_wptr;
  logic [CNT_W-1:0] r_count;

  logic [DLY_W-1:0] w_dly [DEPTH];
  head_state_t      w_head_state;
  wb_payload_t      w_head;
  logic             w_byp;
  logic             w_enq;
  logic             w_deq;

  // One saturating delay counter per storage slot
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dly
    execute_alu_wb_delay_cnt u_dly (
      .clk        (clk),
      .resetn     (resetn),
      .i_load     (w_enq && (r_wptr == PTR_W'(gi))),
      .i_load_val (i_cmtdelay),
      .i_clear    (i_flush),
      .o_cnt      (w_dly[gi])
    );
  end

  assign w_head = r_mem[r_rptr];

  // Head-of-queue decode from occupancy and the head's delay counter
  always_comb begin
    w_head_state = HS_EMPTY;
    if (r_count != '0) begin
      w_head_state = (w_dly[r_rptr] == '0) ? HS_PRESENT : HS_WAIT;
    end
  end

`ifdef EXECUTE_ALU_WB_BYPASS_EN
  assign w_byp = (w_head_state == HS_EMPTY) && i_valid && (i_cmtdelay == '0) && !i_flush;
`else
  assign w_byp = 1'b0;
`endif

  // Full test uses occupancy only, so no path from i_wb_ready to o_ready
  assign o_ready = (r_count < CNT_W'(DEPTH));

  // A bypassed input accepted the same cycle never enters the buffer
  assign w_enq = i_valid && o_ready && !i_flush && !(w_byp && i_wb_ready);
  assign w_deq = (w_head_state == HS_PRESENT) && i_wb_ready && !i_flush;

  // Writeback presentation; zero data whenever nothing is presented
  always_comb begin
    o_wb_valid   = 1'b0;
    o_wb_dst_rob = '0;
    o_wb_fid     = '0;
    o_wb_result  = '0;
    if (w_head_state == HS_PRESENT) begin
      o_wb_valid   = 1'b1;
      o_wb_dst_rob = w_head.rob;
      o_wb_fid     = w_head.fid;
      o_wb_result  = w_head.result;
    end else if (w_byp) begin
      o_wb_valid   = 1'b1;
      o_wb_dst_rob = i_dst_rob;
      o_wb_fid     = i_fid;
      o_wb_result  = i_result;
    end
  end

  // Payload storage; contents are only observed through valid-gated outputs
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wptr] <= '{rob: i_dst_rob, fid: i_fid, result: i_result};
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PTR_W'(1);
      if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

endmodule

// File: tb/tb_execute_alu_wb.sv
// Self-checking bench for execute_alu_wb: directed scenarios followed by
// randomized traffic, all compared against a cycle-stamped queue model.
module tb_execute_alu_wb;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid;
  logic [3:0]  i_dst_rob;
  logic [7:0]  i_fid;
  logic [31:0] i_result;
  logic [3:0]  i_cmtdelay;
  logic        o_ready;
  logic        i_flush;
  logic        o_wb_valid;
  logic [3:0]  o_wb_dst_rob;
  logic [7:0]  o_wb_fid;
  logic [31:0] o_wb_result;
  logic        i_wb_ready;

  execute_alu_wb #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .i_valid      (i_valid),
    .i_dst_rob    (i_dst_rob),
    .i_fid        (i_fid),
    .i_result     (i_result),
    .i_cmtdelay   (i_cmtdelay),
    .o_ready      (o_ready),
    .i_flush      (i_flush),
    .o_wb_valid   (o_wb_valid),
    .o_wb_dst_rob (o_wb_dst_rob),
    .o_wb_fid     (o_wb_fid),
    .o_wb_result  (o_wb_result),
    .i_wb_ready   (i_wb_ready)
  );

  always #5 clk = ~clk;

  // Model entry: payload plus the edge count at which it becomes presentable
  typedef struct {
    logic [3:0]  rob;
    logic [7:0]  fid;
    logic [31:0] res;
    int          due;
  } ent_t;

  ent_t q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Called just after a falling edge: drive, check, advance model over the next rising edge
  task automatic run_cycle(input logic v, input logic [3:0] rob, input logic [7:0] fid,
                           input logic [31:0] res, input logic [3:0] dly,
                           input logic wbr, input logic fl);
    logic        byp;
    logic        head_ok;
    logic        exp_rdy;
    logic        exp_v;
    logic [3:0]  exp_rob;
    logic [7:0]  exp_fid;
    logic [31:0] exp_res;
    i_valid = v; i_dst_rob = rob; i_fid = fid; i_result = res;
    i_cmtdelay = dly; i_wb_ready = wbr; i_flush = fl;
    #1;
    byp = 1'b0;
`ifdef EXECUTE_ALU_WB_BYPASS_EN
    byp = (q.size() == 0) && v && (dly == 4'd0) && !fl;
`endif
    head_ok = (q.size() > 0) && (cyc >= q[0].due);
    exp_rdy = (q.size() < DEPTH);
    exp_v = 1'b0; exp_rob = '0; exp_fid = '0; exp_res = '0;
    if (head_ok) begin
      exp_v = 1'b1; exp_rob = q[0].rob; exp_fid = q[0].fid; exp_res = q[0].res;
    end else if (byp) begin
      exp_v = 1'b1; exp_rob = rob; exp_fid = fid; exp_res = res;
    end
    check("ready",  32'(o_ready),      32'(exp_rdy));
    check("valid",  32'(o_wb_valid),   32'(exp_v));
    check("rob",    32'(o_wb_dst_rob), 32'(exp_rob));
    check("fid",    32'(o_wb_fid),     32'(exp_fid));
    check("result", o_wb_result,       exp_res);
    cyc++;
    if (fl) begin
      q.delete();
    end else begin
      if (head_ok && wbr) void'(q.pop_front());
      if (v && exp_rdy && !(byp && wbr)) q.push_back('{rob, fid, res, cyc + int'(dly)});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic wbr);
    for (int k = 0; k < n; k++) run_cycle(1'b0, 4'h0, 8'h00, 32'h0, 4'h0, wbr, 1'b0);
  endtask

  // Assert reset away from the clock edge and verify outputs clear at once
  task automatic do_reset();
    i_valid = 1'b0; i_flush = 1'b0; i_wb_ready = 1'b1;
    resetn = 1'b0;
    #1;
    check("rst_valid",  32'(o_wb_valid),   32'd0);
    check("rst_ready",  32'(o_ready),      32'd1);
    check("rst_rob",    32'(o_wb_dst_rob), 32'd0);
    check("rst_fid",    32'(o_wb_fid),     32'd0);
    check("rst_result", o_wb_result,       32'd0);
    q.delete();
    @(negedge clk);
    cyc++;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; i_valid = 1'b0; i_dst_rob = '0; i_fid = '0; i_result = '0;
    i_cmtdelay = '0; i_flush = 1'b0; i_wb_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Zero-delay single result
    run_cycle(1'b1, 4'd3, 8'h12, 32'hDEADBEEF, 4'd0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Delay of five cycles
    run_cycle(1'b1, 4'd7, 8'h34, 32'h0BADF00D, 4'd5, 1'b1, 1'b0);
    idle(8, 1'b1);

    // Fill while blocked, then drain in order
    for (int k = 0; k < 4; k++)
      run_cycle(1'b1, 4'(k + 1), 8'(8'h40 + k), 32'hA000_0000 + 32'(k), 4'd0, 1'b0, 1'b0);
    idle(1, 1'b0);
    idle(6, 1'b1);

    // Steady occupancy of two with enqueue and dequeue every edge
    run_cycle(1'b1, 4'd1, 8'h50, 32'h5000_0000, 4'd0, 1'b0, 1'b0);
    run_cycle(1'b1, 4'd2, 8'h51, 32'h5000_0001, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++)
      run_cycle(1'b1, 4'(k), 8'(8'h60 + k), 32'h6000_0000 + 32'(k), 4'd0, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Flush with three held plus a new input
    for (int k = 0; k < 3; k++)
      run_cycle(1'b1, 4'(k + 8), 8'(8'h70 + k), 32'h7000_0000 + 32'(k), 4'd0, 1'b0, 1'b0);
    run_cycle(1'b1, 4'd15, 8'hFF, 32'hFFFF_0001, 4'd0, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Reset mid-drain
    for (int k = 0; k < 3; k++)
      run_cycle(1'b1, 4'(k + 4), 8'(8'h80 + k), 32'h8000_0000 + 32'(k), 4'd1, 1'b0, 1'b0);
    idle(2, 1'b1);
    do_reset();
    idle(5, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        run_cycle(1'($urandom_range(0, 99) < 60), 4'($urandom), 8'($urandom), 32'($urandom),
                  4'($urandom_range(0, 6)), 1'($urandom_range(0, 99) < 65),
                  1'($urandom_range(0, 39) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
